hop_chain_sequencer: RTL and testbench



---
 rtl/hop_seq_pkg.sv | 23 ++
 rtl/hop_lat_meter.sv | 50 +++++
 rtl/hop_chain_sequencer.sv | 159 +++++++++++++++
 tb/tb_hop_chain_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hop_seq_pkg.sv
// Shared types and defaults for the hop-chain benchmark sequencer.
package hop_seq_pkg;

  localparam int unsigned N_RST_DEF      = 14;
  localparam int unsigned RST_CYCLES_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 64;
  localparam int unsigned CNT_W_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RELEASE,
    LAUNCH,
    WAIT,
    DONE
  } seq_state_t;

  // All-ones value of a w-bit latency field (saturation / timeout marker).
  function automatic logic [63:0] lat_sat(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/hop_lat_meter.sv
// One chain's latency meter: saturating counter, first-rise capture, timeout fill.
module hop_lat_meter
  import hop_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             clr,
  input  logic             en,
  input  logic             expire,
  input  logic             tap,
  output logic             seen,
  output logic             limit,
  output logic [CNT_W-1:0] lat
);

  localparam logic [CNT_W-1:0] LAT_SAT = CNT_W'(lat_sat(CNT_W));
  localparam logic [CNT_W-1:0] LIM     = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // The edge that moves the counter to TIMEOUT is the last one of the window.
  assign limit = en && (cnt == LIM);

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      cnt  <= '0;
      lat  <= '0;
      seen <= 1'b0;
    end else begin
      if (!en)
        cnt <= '0;
      else if (cnt != LAT_SAT)
        cnt <= cnt + 1'b1;

      if (clr) begin
        lat  <= '0;
        seen <= 1'b0;
      end else if (en && !seen && tap) begin
        lat  <= cnt;
        seen <= 1'b1;
      end else if (expire && !seen) begin
        lat <= LAT_SAT;
      end
    end
  end

endmodule

// File: rtl/hop_chain_sequencer.sv
// Hold/release/launch/measure controller for the two hop-chain benchmarks.
// Optional staggered per-stage reset release: HOP_SEQ_STAGGER_EN.
module hop_chain_sequencer
  import hop_seq_pkg::*;
#(
  parameter int unsigned N_RST      = N_RST_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             go,
  input  logic             tap_a,
  input  logic             tap_b,
  output logic [N_RST-1:0] chain_rst,
  output logic             start_a,
  output logic             start_b,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err_stuck,
  output logic [CNT_W-1:0] lat_a,
  output logic [CNT_W-1:0] lat_b
);

`ifdef HOP_SEQ_STAGGER_EN
  localparam int unsigned REL_STEPS = N_RST;
`else
  localparam int unsigned REL_STEPS = 1;
`endif
  localparam int unsigned PH_MAX = (RST_CYCLES > REL_STEPS) ? RST_CYCLES : REL_STEPS;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  seq_state_t       state, state_nxt;
  logic [PH_W-1:0]  ph, ph_nxt;
  logic [N_RST-1:0] chain_rst_nxt;
  logic             start_q, start_nxt;
  logic             busy_nxt, done_nxt, timeout_nxt, stuck_nxt;
  logic             clr, meas_en, expire, both;
  logic             seen_a, seen_b, limit_a, limit_b;

  assign meas_en = (state == LAUNCH) || (state == WAIT);
  assign both    = (seen_a || tap_a) && (seen_b || tap_b);
  assign start_a = start_q;
  assign start_b = start_q;

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state     <= IDLE;
      ph        <= '0;
      chain_rst <= '1;
      start_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_stuck <= 1'b0;
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      chain_rst <= chain_rst_nxt;
      start_q   <= start_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
      err_stuck <= stuck_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ph_nxt        = ph;
    chain_rst_nxt = chain_rst;
    start_nxt     = start_q;
    busy_nxt      = busy;
    done_nxt      = done;
    timeout_nxt   = timeout;
    stuck_nxt     = err_stuck;
    clr           = 1'b0;
    expire        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_nxt   = HOLD;
          ph_nxt      = '0;
          busy_nxt    = 1'b1;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          stuck_nxt   = 1'b0;
          clr         = 1'b1;
        end
      end
      HOLD: begin
        chain_rst_nxt = '1;
        start_nxt     = 1'b0;
        if (ph == PH_W'(RST_CYCLES - 1)) begin
          state_nxt = RELEASE;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph + 1'b1;
        end
      end
      RELEASE: begin
        if (tap_a || tap_b)
          stuck_nxt = 1'b1;
        // ph counts release steps; one extra cycle settles before launch.
        if (ph < PH_W'(REL_STEPS)) begin
          ph_nxt = ph + 1'b1;
`ifdef HOP_SEQ_STAGGER_EN
          chain_rst_nxt[ph] = 1'b0;
`else
          chain_rst_nxt = '0;
`endif
        end else begin
          state_nxt = LAUNCH;
          start_nxt = 1'b1;
        end
      end
      LAUNCH, WAIT: begin
        state_nxt = WAIT;
        expire    = !both && (limit_a || limit_b);
        if (both || expire) begin
          state_nxt     = DONE;
          busy_nxt      = 1'b0;
          done_nxt      = 1'b1;
          start_nxt     = 1'b0;
          chain_rst_nxt = '1;
          timeout_nxt   = expire;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  hop_lat_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_meter_a (
    .clock0 (clock0),
    .rst1   (rst1),
    .clr    (clr),
    .en     (meas_en),
    .expire (expire),
    .tap    (tap_a),
    .seen   (seen_a),
    .limit  (limit_a),
    .lat    (lat_a)
  );

  hop_lat_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_meter_b (
    .clock0 (clock0),
    .rst1   (rst1),
    .clr    (clr),
    .en     (meas_en),
    .expire (expire),
    .tap    (tap_b),
    .seen   (seen_b),
    .limit  (limit_b),
    .lat    (lat_b)
  );

endmodule

// File: tb/tb_hop_chain_sequencer.sv
// Directed bench: models two shift chains and checks latency/status outcomes.
module tb_hop_chain_sequencer;

  localparam int N_RST      = 14;
  localparam int RST_CYCLES = 4;
  localparam int TIMEOUT    = 64;
  localparam int CNT_W      = 8;
`ifdef HOP_SEQ_STAGGER_EN
  localparam int REL_CYC = N_RST + 1;
`else
  localparam int REL_CYC = 2;
`endif
  localparam int BUSY_EXP = RST_CYCLES + REL_CYC + 9;

  logic             clock0 = 1'b0;
  logic             rst1   = 1'b1;
  logic             go     = 1'b0;
  logic             tap_a, tap_b;
  logic [N_RST-1:0] chain_rst;
  logic             start_a, start_b, busy, done, timeout, err_stuck;
  logic [CNT_W-1:0] lat_a, lat_b;

  int   checks   = 0;
  int   failures = 0;
  int   len_a    = 8;
  int   len_b    = 8;
  logic stuck_a  = 1'b0;
  logic [15:0] sra, srb;

  int   busy_cnt, launch_cnt, b_first_lat, b_first_done;
  int   drop [N_RST];
  logic finished;

  hop_chain_sequencer #(
    .N_RST(N_RST), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock0(clock0), .rst1(rst1), .go(go), .tap_a(tap_a), .tap_b(tap_b),
    .chain_rst(chain_rst), .start_a(start_a), .start_b(start_b),
    .busy(busy), .done(done), .timeout(timeout), .err_stuck(err_stuck),
    .lat_a(lat_a), .lat_b(lat_b)
  );

  always #5 clock0 = ~clock0;

  always_ff @(posedge clock0) begin
    if (chain_rst[0]) begin
      sra <= '0;
      srb <= '0;
    end else begin
      sra <= {sra[14:0], start_a};
      srb <= {srb[14:0], start_b};
    end
  end

  always_comb begin
    tap_a = stuck_a;
    tap_b = 1'b0;
    if (len_a > 0) tap_a = tap_a | sra[len_a-1];
    if (len_b > 0) tap_b = srb[len_b-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete run; go_mid >= 0 re-pulses go at that cycle while busy.
  task automatic run_once(input int go_mid);
    busy_cnt = 0; launch_cnt = 0; b_first_lat = -1; b_first_done = -1;
    finished = 1'b0;
    for (int k = 0; k < N_RST; k++) drop[k] = -1;
    @(negedge clock0);
    go = 1'b1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clock0);
      go = (cyc == go_mid);
      if (busy) busy_cnt++;
      if (start_a && !done) launch_cnt++;
      for (int k = 0; k < N_RST; k++)
        if (!chain_rst[k] && drop[k] < 0) drop[k] = cyc;
      if (lat_b != 0 && b_first_lat < 0) begin
        b_first_lat  = int'(lat_b);
        b_first_done = int'(done);
      end
      if (done) finished = 1'b1;
    end
    go = 1'b0;
    check("run_finished", 32'(finished), 1);
  endtask

  initial begin
    repeat (3) @(negedge clock0);
    check("rst_chain_rst", 32'(chain_rst), 32'h3FFF);
    check("rst_start", {30'd0, start_a, start_b}, 0);
    check("rst_flags", {28'd0, busy, done, timeout, err_stuck}, 0);
    check("rst_lats", {16'd0, lat_a, lat_b}, 0);
    rst1 = 1'b0;
    repeat (2) @(negedge clock0);

    // Nominal 8/8 chains with a go pulse while busy.
    len_a = 8; len_b = 8;
    run_once(2);
    check("nom_lat_a", 32'(lat_a), 8);
    check("nom_lat_b", 32'(lat_b), 8);
    check("nom_timeout", 32'(timeout), 0);
    check("nom_stuck", 32'(err_stuck), 0);
    check("nom_busy_cycles", busy_cnt, BUSY_EXP);
    check("nom_launch_cycles", launch_cnt, 9);
    check("nom_drop0", drop[0], RST_CYCLES + 1);
    for (int k = 1; k < N_RST; k++)
`ifdef HOP_SEQ_STAGGER_EN
      check($sformatf("drop_bit%0d", k), drop[k], drop[0] + k);
`else
      check($sformatf("drop_bit%0d", k), drop[k], drop[0]);
`endif
    @(negedge clock0);
    check("done_rehold", 32'(chain_rst), 32'h3FFF);
    check("done_start", {30'd0, start_a, start_b}, 0);
    check("done_held", {30'd0, busy, done}, 1);

    // Unequal chains: B (5) captured while run still busy.
    len_b = 5;
    run_once(-1);
    check("uneq_b_first", b_first_lat, 5);
    check("uneq_b_first_done", b_first_done, 0);
    check("uneq_lat_a", 32'(lat_a), 8);
    check("uneq_lat_b", 32'(lat_b), 5);
    check("uneq_launch_cycles", launch_cnt, 9);

    // Timeout: tap_b never rises.
    len_b = 0;
    run_once(-1);
    check("to_timeout", 32'(timeout), 1);
    check("to_lat_a", 32'(lat_a), 8);
    check("to_lat_b", 32'(lat_b), 32'hFF);
    check("to_launch_cycles", launch_cnt, TIMEOUT);
    check("to_busy", 32'(busy), 0);

    // Stuck tap_a.
    len_b = 8; stuck_a = 1'b1;
    run_once(-1);
    check("stuck_flag", 32'(err_stuck), 1);
    check("stuck_lat_a", 32'(lat_a), 0);
    check("stuck_lat_b", 32'(lat_b), 8);
    check("stuck_timeout", 32'(timeout), 0);
    stuck_a = 1'b0;

    // Async reset mid-WAIT after lat_b has been captured.
    len_b = 5;
    @(negedge clock0); go = 1'b1;
    @(negedge clock0); go = 1'b0;
    for (int cyc = 0; cyc < 100 && lat_b == 0; cyc++) @(negedge clock0);
    check("mid_lat_b", 32'(lat_b), 5);
    check("mid_busy", 32'(busy), 1);
    #2 rst1 = 1'b1;
    #1;
    check("arst_chain_rst", 32'(chain_rst), 32'h3FFF);
    check("arst_start", {30'd0, start_a, start_b}, 0);
    check("arst_flags", {28'd0, busy, done, timeout, err_stuck}, 0);
    check("arst_lats", {16'd0, lat_a, lat_b}, 0);
    check("arst_state", 32'(dut.state), 32'(hop_seq_pkg::IDLE));
    @(negedge clock0); rst1 = 1'b0;
    @(negedge clock0);

    // Recovery run after reset.
    len_b = 8;
    run_once(-1);
    check("rec_lat_a", 32'(lat_a), 8);
    check("rec_lat_b", 32'(lat_b), 8);
    check("rec_busy_cycles", busy_cnt, BUSY_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
